// File: rtl/ring_meas_sequencer.sv
// Time-shares one gated pulse counter across several ring oscillators:
// select ring, clear, gate for a fixed window, settle, latch, then hand off the result.
module ring_meas_sequencer #(
    parameter int NUM_RINGS     = 4,
    parameter int SEL_W         = 2,
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 100,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    input  logic [NUM_RINGS-1:0] ring_en,
    input  logic [CNT_W-1:0]     cnt_value,
    input  logic                 cnt_ovf,
    output logic [SEL_W-1:0]     ring_sel,
    output logic                 cnt_clr,
    output logic                 gate_en,
    output logic [CNT_W-1:0]     result,
    output logic [SEL_W-1:0]     result_ring,
    output logic                 result_ovf,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, GATE, SETTLE, LATCH, PRESENT
    } state_t;

    localparam logic [15:0] CLEAR_LOAD  = 16'd1;
    localparam logic [15:0] GATE_LOAD   = 16'(GATE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [15:0]        tmr_q, tmr_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   ring_sel_q, ring_sel_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic [SEL_W-1:0]   result_ring_q, result_ring_d;
    logic               result_ovf_q, result_ovf_d;

    // First enabled ring at or above p, wrapping at NUM_RINGS-1.
    function automatic logic [SEL_W-1:0] next_ring(input logic [SEL_W-1:0] p,
                                                   input logic [NUM_RINGS-1:0] en);
        logic [SEL_W-1:0] r;
        logic             found;
        int               idx;
        r     = p;
        found = 1'b0;
        for (int k = 0; k < NUM_RINGS; k++) begin
            idx = (int'(p) + k) % NUM_RINGS;
            if (!found && en[idx]) begin
                r     = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        ptr_d         = ptr_q;
        ring_sel_d    = ring_sel_q;
        result_d      = result_q;
        result_ring_d = result_ring_q;
        result_ovf_d  = result_ovf_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (|ring_en)) begin
                        ring_sel_d = next_ring(ptr_q, ring_en);
                        tmr_d      = CLEAR_LOAD;
                        state_d    = CLEAR;
                    end
                end
                CLEAR: begin
                    if (tmr_q == 16'd0) begin
                        tmr_d   = GATE_LOAD;
                        state_d = GATE;
                    end else begin
                        tmr_d = tmr_q - 16'd1;
                    end
                end
                GATE: begin
                    if (tmr_q == 16'd0) begin
                        tmr_d   = SETTLE_LOAD;
                        state_d = SETTLE;
                    end else begin
                        tmr_d = tmr_q - 16'd1;
                    end
                end
                SETTLE: begin
                    if (tmr_q == 16'd0) state_d = LATCH;
                    else                tmr_d   = tmr_q - 16'd1;
                end
                LATCH: begin
                    result_d      = cnt_value;
                    result_ovf_d  = cnt_ovf;
                    result_ring_d = ring_sel_q;
                    ptr_d         = (ring_sel_q == SEL_W'(NUM_RINGS - 1)) ? '0 : ring_sel_q + 1'b1;
                    state_d       = PRESENT;
                end
                PRESENT: begin
                    if (result_ready) begin
                        // ptr already advanced in LATCH, so the search resumes past this ring
                        if (continuous && (|ring_en)) begin
                            ring_sel_d = next_ring(ptr_q, ring_en);
                            tmr_d      = CLEAR_LOAD;
                            state_d    = CLEAR;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            ptr_q         <= '0;
            ring_sel_q    <= '0;
            result_q      <= '0;
            result_ring_q <= '0;
            result_ovf_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            ptr_q         <= ptr_d;
            ring_sel_q    <= ring_sel_d;
            result_q      <= result_d;
            result_ring_q <= result_ring_d;
            result_ovf_q  <= result_ovf_d;
        end
    end

    // Decoded straight from the state flop so reset drops them immediately.
    assign cnt_clr      = (state_q == CLEAR);
    assign gate_en      = (state_q == GATE);
    assign result_valid = (state_q == PRESENT);
    assign busy         = (state_q != IDLE);
    assign ring_sel     = ring_sel_q;
    assign result       = result_q;
    assign result_ring  = result_ring_q;
    assign result_ovf   = result_ovf_q;

endmodule

// File: tb/tb_ring_meas_sequencer.sv
// Randomized scoreboard bench for ring_meas_sequencer with a behavioural counter and ring-selection model.
module tb_ring_meas_sequencer;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int CW = 16;
    localparam int G  = 100;
    localparam int S  = 4;

    logic          clk, rst, start, continuous, abort, result_ready;
    logic [N-1:0]  ring_en;
    logic [CW-1:0] cnt_value;
    logic          cnt_ovf;
    logic [SW-1:0] ring_sel, result_ring;
    logic          cnt_clr, gate_en, result_ovf, result_valid, busy;
    logic [CW-1:0] result;

    ring_meas_sequencer #(.NUM_RINGS(N), .SEL_W(SW), .CNT_W(CW),
                          .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .ring_en(ring_en), .cnt_value(cnt_value), .cnt_ovf(cnt_ovf),
        .ring_sel(ring_sel), .cnt_clr(cnt_clr), .gate_en(gate_en),
        .result(result), .result_ring(result_ring), .result_ovf(result_ovf),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter model: each ring adds a fixed increment per gated cycle, wrap sets a sticky flag.
    int unsigned   inc [N];
    logic [CW:0]   cnt_nxt;
    assign cnt_nxt = {1'b0, cnt_value} + (CW+1)'(inc[ring_sel]);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_value <= '0;
            cnt_ovf   <= 1'b0;
        end else if (cnt_clr) begin
            cnt_value <= '0;
            cnt_ovf   <= 1'b0;
        end else if (gate_en) begin
            cnt_value <= cnt_nxt[CW-1:0];
            if (cnt_nxt[CW]) cnt_ovf <= 1'b1;
        end
    end

    typedef struct {
        logic [SW-1:0] ring;
        logic [CW-1:0] val;
        logic          ovf;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   nhs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t predict(input int p, input logic [N-1:0] m);
        exp_t        e;
        int          r;
        longint      prod;
        r = -1;
        for (int k = 0; k < N; k++)
            if (r < 0 && m[(p + k) % N]) r = (p + k) % N;
        prod   = longint'(G) * longint'(inc[r]);
        e.ring = SW'(r);
        e.val  = CW'(prod % 65536);
        e.ovf  = (prod >= 65536);
        return e;
    endfunction

    // Model + monitor, sampling on the falling edge where inputs and outputs are stable.
    initial begin
        int   mptr, t0, nclr, ngate;
        bit   mbusy, hs_chk, exp_clr;
        logic prev_v, prev_clr;
        mptr = 0; mbusy = 0; hs_chk = 0; exp_clr = 0;
        prev_v = 0; prev_clr = 0; t0 = 0; nclr = 0; ngate = 0;
        cur = '{ring: '0, val: '0, ovf: 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                mptr = 0; mbusy = 0; hs_chk = 0;
                prev_v = 0; prev_clr = 0;
                cur = '{ring: '0, val: '0, ovf: 1'b0};
                continue;
            end
            if (cnt_clr && !prev_clr) begin
                t0 = cyc; nclr = 0; ngate = 0;
            end
            if (cnt_clr) nclr++;
            if (gate_en) begin
                ngate++;
                if (q.size() > 0) chk("ring_sel_during_gate", ring_sel, q[0].ring);
            end
            if (hs_chk) begin
                chk("valid_after_handshake", result_valid, 0);
                chk("clear_after_handshake", cnt_clr, exp_clr);
                hs_chk = 0;
            end
            if (result_valid && !prev_v) begin
                chk("valid_latency", cyc - t0, G + S + 3);
                chk("clr_cycles", nclr, 2);
                chk("gate_cycles", ngate, G);
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result actual=valid required=no_result (t=%0t)", $time);
                end else begin
                    cur = q.pop_front();
                    chk("result", result, cur.val);
                    chk("result_ring", result_ring, cur.ring);
                    chk("result_ovf", result_ovf, cur.ovf);
                end
            end else if (result_valid) begin
                chk("result_hold", result, cur.val);
                chk("result_ring_hold", result_ring, cur.ring);
            end
            if (abort) begin
                if (mbusy && q.size() > 0) void'(q.pop_back());
                mbusy = 0;
            end else if (!mbusy) begin
                if (start && ring_en != 0) begin
                    q.push_back(predict(mptr, ring_en));
                    mbusy = 1;
                end
            end else if (result_valid && result_ready) begin
                nhs++;
                mptr    = (int'(cur.ring) + 1) % N;
                hs_chk  = 1;
                exp_clr = continuous && (ring_en != 0);
                if (exp_clr) q.push_back(predict(mptr, ring_en));
                else         mbusy = 0;
            end
            prev_v   = result_valid;
            prev_clr = cnt_clr;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(1); n++; end
        chk(name, busy, 0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!result_valid && n < budget) begin tick(1); n++; end
        chk(name, result_valid, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] saved;
        int            target, n;
        rst = 1'b1; start = 0; continuous = 0; abort = 0; result_ready = 0; ring_en = '0;
        for (int i = 0; i < N; i++) inc[i] = $urandom_range(50, 700);
        tick(2);
        chk("rst_ring_sel", ring_sel, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_gate_en", gate_en, 0);
        chk("rst_result", result, 0);
        chk("rst_result_ring", result_ring, 0);
        chk("rst_result_ovf", result_ovf, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // single shot from ring 0
        ring_en = 4'b1111; result_ready = 1;
        pulse_start();
        wait_idle("single_shot_timeout", 300);
        tick(3);

        // round robin over rings 1 and 3
        ring_en = 4'b1010; continuous = 1;
        target = nhs + 4;
        pulse_start();
        n = 0;
        while (nhs < target && n < 1000) begin tick(1); n++; end
        chk("round_robin_count", (nhs >= target), 1);
        continuous = 0;
        wait_idle("round_robin_timeout", 300);

        // backpressure with a continuous follow-on
        ring_en = 4'b1111; continuous = 1; result_ready = 0;
        pulse_start();
        wait_valid("bp_valid_timeout", 300);
        tick(50);
        chk("bp_valid_held", result_valid, 1);
        result_ready = 1;
        tick(1);
        continuous = 0;
        wait_idle("bp_timeout", 300);

        // abort at gate cycle 40
        saved = result;
        pulse_start();
        n = 0;
        while (!gate_en && n < 20) begin tick(1); n++; end
        tick(39);
        chk("abort_pre_gate", gate_en, 1);
        abort = 1;
        tick(1);
        abort = 0;
        chk("abort_gate_en", gate_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_result_kept", result, saved);
        tick(5);

        // forced overflow on ring 2
        inc[2] = 900; ring_en = 4'b0100;
        pulse_start();
        wait_idle("ovf_timeout", 300);

        // start with no rings enabled, and start with abort
        ring_en = '0;
        pulse_start();
        chk("empty_mask_busy", busy, 0);
        ring_en = 4'b1111; abort = 1;
        pulse_start();
        abort = 0;
        chk("start_abort_busy", busy, 0);
        tick(2);
        chk("start_abort_still_idle", busy, 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            result_ready = ($urandom_range(0, 3) != 0);
            start        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) continuous = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0) ring_en = N'($urandom_range(0, 15));
            abort = ($urandom_range(0, 399) == 0) && !result_valid;
            tick(1);
        end
        start = 0; abort = 0; continuous = 0; result_ready = 1; ring_en = 4'b1111;
        wait_idle("random_drain_timeout", 400);
        chk("scoreboard_empty", q.size(), 0);

        // async reset while presenting
        result_ready = 0;
        pulse_start();
        wait_valid("arst_valid_timeout", 300);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", result_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ring_sel", ring_sel, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
